// File: rtl/wb_shared_bus.sv
// Wishbone B4 pipelined shared bus: NM masters, NS decoded slaves, one transfer in flight.
// Optional slave watchdog enabled by defining WB_SHARED_TIMEOUT_EN.
module wb_shared_bus #(
    parameter int unsigned      NM         = 2,
    parameter int unsigned      NS         = 5,
    parameter int unsigned      AW         = 32,
    parameter int unsigned      DW         = 32,
    parameter logic [NS*AW-1:0] SLAVE_ADDR = '0,
    parameter logic [NS*AW-1:0] SLAVE_MASK = '0,
    parameter int unsigned      TIMEOUT    = 1023
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NM-1:0]         m_cyc_i,
    input  logic [NM-1:0]         m_stb_i,
    input  logic [NM-1:0]         m_we_i,
    input  logic [NM*AW-1:0]      m_adr_i,
    input  logic [NM*DW-1:0]      m_dat_i,
    input  logic [NM*(DW/8)-1:0]  m_sel_i,
    output logic [NM-1:0]         m_ack_o,
    output logic [NM-1:0]         m_err_o,
    output logic [NM-1:0]         m_stall_o,
    output logic [DW-1:0]         m_dat_o,
    output logic [NM-1:0]         grant_o,
    output logic [NS-1:0]         s_cyc_o,
    output logic [NS-1:0]         s_stb_o,
    output logic                  s_we_o,
    output logic [AW-1:0]         s_adr_o,
    output logic [DW-1:0]         s_dat_o,
    output logic [(DW/8)-1:0]     s_sel_o,
    input  logic [NS-1:0]         s_ack_i,
    input  logic [NS-1:0]         s_err_i,
    input  logic [NS-1:0]         s_stall_i,
    input  logic [NS*DW-1:0]      s_dat_i
);
    localparam int unsigned SW = DW / 8;
    localparam int unsigned LW = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned KW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t         state_q, state_d;
    logic [NM-1:0]  grant_q, grant_d;
    logic [LW-1:0]  owner_q, owner_d;
    logic [LW-1:0]  last_q, last_d;
    logic           pend_q, pend_d;
    logic           decerr_q, decerr_d;
    logic [KW-1:0]  sidx_q, sidx_d;

    logic [31:0]    own_i;
    logic           own_cyc, own_stb, own_we;
    logic [AW-1:0]  own_adr;
    logic [DW-1:0]  own_dat;
    logic [SW-1:0]  own_sel;

    logic           dec_hit;
    logic [KW-1:0]  dec_idx;
    logic           arb_any;
    logic [LW-1:0]  arb_idx;
    int             arb_j;

    logic           own_stall, accept, rsp_ack, rsp_err, tmo_hit;

    assign grant_o = grant_q;

    // Owner's request signals
    assign own_i   = 32'(owner_q);
    assign own_cyc = m_cyc_i[owner_q];
    assign own_stb = m_stb_i[owner_q];
    assign own_we  = m_we_i[owner_q];
    assign own_adr = m_adr_i[own_i*AW +: AW];
    assign own_dat = m_dat_i[own_i*DW +: DW];
    assign own_sel = m_sel_i[own_i*SW +: SW];

    // Address decode; scanning downward lets the lowest matching index win
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int k = int'(NS) - 1; k >= 0; k--) begin
            if ((own_adr & SLAVE_MASK[k*AW +: AW]) == SLAVE_ADDR[k*AW +: AW]) begin
                dec_hit = 1'b1;
                dec_idx = KW'(k);
            end
        end
    end

    // Round-robin: first requester at or after last+1
    always_comb begin
        arb_any = 1'b0;
        arb_idx = last_q;
        arb_j   = 0;
        for (int i = 1; i <= int'(NM); i++) begin
            arb_j = (int'(last_q) + i) % int'(NM);
            if (!arb_any && m_cyc_i[LW'(arb_j)]) begin
                arb_any = 1'b1;
                arb_idx = LW'(arb_j);
            end
        end
    end

`ifdef WB_SHARED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;

    assign tmo_hit = pend_q && !decerr_q && (tmo_q == TW'(TIMEOUT - 1));

    // Watchdog: restarts on each accepted strobe, counts pending cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else if (accept) begin
            tmo_q <= '0;
        end else if (pend_q) begin
            tmo_q <= tmo_q + TW'(1);
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign tmo_hit        = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            last_q   <= LW'(NM - 1);
            pend_q   <= 1'b0;
            decerr_q <= 1'b0;
            sidx_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            decerr_q <= decerr_d;
            sidx_q   <= sidx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        last_d    = last_q;
        pend_d    = pend_q;
        decerr_d  = decerr_q;
        sidx_d    = sidx_q;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_stall_o = m_cyc_i;
        m_dat_o   = '0;
        s_cyc_o   = '0;
        s_stb_o   = '0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        own_stall = 1'b0;
        accept    = 1'b0;
        rsp_ack   = 1'b0;
        rsp_err   = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d  = OWNED;
                    owner_d  = arb_idx;
                    grant_d  = NM'(1) << arb_idx;
                    pend_d   = 1'b0;
                    decerr_d = 1'b0;
                end
            end
            OWNED: begin
                if (!own_cyc) begin
                    // Release: any in-flight response is dropped
                    state_d  = IDLE;
                    grant_d  = '0;
                    last_d   = owner_q;
                    pend_d   = 1'b0;
                    decerr_d = 1'b0;
                end else begin
                    s_we_o  = own_we;
                    s_adr_o = own_adr;
                    s_dat_o = own_dat;
                    s_sel_o = own_sel;
                    if (pend_q) begin
                        own_stall = 1'b1;
                        if (decerr_q) begin
                            rsp_err = 1'b1;
                        end else begin
                            s_cyc_o[sidx_q] = !tmo_hit;
                            rsp_err = s_err_i[sidx_q] | tmo_hit;
                            rsp_ack = s_ack_i[sidx_q] & !rsp_err;
                            m_dat_o = s_dat_i[32'(sidx_q)*DW +: DW];
                        end
                        if (rsp_ack || rsp_err) begin
                            pend_d   = 1'b0;
                            decerr_d = 1'b0;
                        end
                    end else begin
                        if (dec_hit) begin
                            s_cyc_o[dec_idx] = 1'b1;
                            s_stb_o[dec_idx] = own_stb;
                            own_stall        = s_stall_i[dec_idx];
                        end
                        accept = own_stb && !own_stall;
                        if (accept) begin
                            pend_d   = 1'b1;
                            decerr_d = !dec_hit;
                            sidx_d   = dec_idx;
                        end
                    end
                    m_stall_o[owner_q] = own_stall;
                    m_ack_o[owner_q]   = rsp_ack;
                    m_err_o[owner_q]   = rsp_err;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_wb_shared_bus.sv
// Scoreboard bench for wb_shared_bus: two masters, RAM slave at 0x00xxxxxx, register slave at 0x01xxxxxx.
module tb_wb_shared_bus;
    localparam int unsigned NM = 2;
    localparam int unsigned NS = 2;
    localparam logic [63:0] S_ADDR = {32'h0100_0000, 32'h0000_0000};
    localparam logic [63:0] S_MASK = {32'hff00_0000, 32'hff00_0000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  m_cyc = '0, m_stb = '0, m_we = '0;
    logic [63:0] m_adr = '0, m_dat = '0;
    logic [7:0]  m_sel = '0;
    logic [1:0]  m_ack_o, m_err_o, m_stall_o, grant_o, s_cyc_o, s_stb_o;
    logic [31:0] m_dat_o, s_adr_o, s_dat_o;
    logic        s_we_o;
    logic [3:0]  s_sel_o;

    logic        s0_ack = 1'b0, s1_ack = 1'b0;
    logic [31:0] s0_rdat = '0, s1_rdat = '0;
    logic [31:0] mem [0:15];
    int          s0_delay = 1, s0_cnt = 0;
    bit          s0_noack = 1'b0, s0_busy = 1'b0;

    typedef struct { int m; bit err; bit chk_dat; logic [31:0] dat; } exp_t;
    exp_t sb_q[$];
    exp_t e;
    int checks = 0, errors = 0;

    logic [1:0] arb_cyc [0:12] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11, 2'b11,
                                   2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11};
    logic [1:0] arb_gnt [0:12] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10,
                                   2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};

    always #5 clk = ~clk;

    wb_shared_bus #(
        .NM(NM), .NS(NS), .AW(32), .DW(32),
        .SLAVE_ADDR(S_ADDR), .SLAVE_MASK(S_MASK), .TIMEOUT(8)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_stall_o(m_stall_o),
        .m_dat_o(m_dat_o), .grant_o(grant_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_ack_i({s1_ack, s0_ack}), .s_err_i(2'b00), .s_stall_i(2'b00),
        .s_dat_i({s1_rdat, s0_rdat})
    );

    // RAM slave with programmable ack latency or no ack at all
    always @(posedge clk) begin
        s0_ack <= 1'b0;
        if (s0_busy) begin
            if (s0_cnt <= 1) begin
                s0_ack  <= 1'b1;
                s0_busy <= 1'b0;
            end else begin
                s0_cnt <= s0_cnt - 1;
            end
        end else if (s_cyc_o[0] && s_stb_o[0]) begin
            if (s_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (s_sel_o[b]) mem[s_adr_o[5:2]][b*8 +: 8] <= s_dat_o[b*8 +: 8];
            end
            s0_rdat <= mem[s_adr_o[5:2]];
            if (!s0_noack) begin
                if (s0_delay <= 1) s0_ack <= 1'b1;
                else begin
                    s0_busy <= 1'b1;
                    s0_cnt  <= s0_delay - 1;
                end
            end
        end
    end

    // Register slave: one-cycle ack, data derived from address
    always @(posedge clk) begin
        s1_ack <= s_cyc_o[1] && s_stb_o[1];
        if (s_cyc_o[1] && s_stb_o[1]) s1_rdat <= 32'hA5A5_0000 | {16'h0, s_adr_o[15:0]};
    end

    // Monitor: every ack/err pops one expected response
    initial forever begin
        @(negedge clk);
        for (int m = 0; m < int'(NM); m++) begin
            if (m_ack_o[m] || m_err_o[m]) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp m%0d: got ack %0b err %0b, want no response",
                             m, m_ack_o[m], m_err_o[m]);
                end else begin
                    e = sb_q.pop_front();
                    if (e.m != m || m_err_o[m] !== e.err || m_ack_o[m] !== !e.err ||
                        (e.chk_dat && m_dat_o !== e.dat)) begin
                        errors++;
                        $display("FAIL rsp m%0d: got ack %0b err %0b dat %h, want m%0d err %0b dat %h",
                                 m, m_ack_o[m], m_err_o[m], m_dat_o, e.m, e.err, e.dat);
                    end
                end
            end
        end
    end

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst   = 1'b1;
        m_cyc = '0;
        m_stb = '0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_outputs",
                 {m_ack_o, m_err_o, m_stall_o, grant_o, s_cyc_o, s_stb_o, s_we_o,
                  m_dat_o, s_adr_o, s_dat_o, s_sel_o}, '0);
    endtask

    // Present a strobe and hold it until accepted; returns just after the accepting edge
    task automatic issue(input int m, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         output int wcyc, output logic [1:0] sstb);
        m_we[m]          = we;
        m_adr[m*32 +: 32] = adr;
        m_dat[m*32 +: 32] = dat;
        m_sel[m*4 +: 4]   = 4'hF;
        m_stb[m]         = 1'b1;
        wcyc = 0;
        @(negedge clk);
        while (m_stall_o[m] && wcyc < 50) begin
            wcyc++;
            @(negedge clk);
        end
        sstb = s_stb_o;
        if (m_stall_o[m]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout m%0d: got stall 1 after %0d cycles, want 0", m, wcyc);
        end
        next_cycle();
        m_stb[m] = 1'b0;
    endtask

    task automatic wait_rsp(input int m, input int lim, output int lat);
        lat = 1;
        @(negedge clk);
        while (!(m_ack_o[m] || m_err_o[m]) && lat < lim) begin
            lat++;
            @(negedge clk);
        end
        if (!(m_ack_o[m] || m_err_o[m])) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout m%0d: got no response in %0d cycles, want one", m, lim);
        end
    endtask

    initial begin
        int w, lat, cnt, seen;
        logic [1:0] ss;

        do_reset();

        // Single master write then back-to-back readback on the RAM
        next_cycle();
        m_cyc[0] = 1'b1;
        sb_q.push_back('{0, 1'b0, 1'b0, 32'h0});
        issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, w, ss);
        check_eq("grant_m0", grant_o, 2'b01);
        check_eq("grant_latency", w, 1);
        wait_rsp(0, 20, lat);
        check_eq("wr_latency", lat, 1);
        next_cycle();
        sb_q.push_back('{0, 1'b0, 1'b1, 32'hDEAD_BEEF});
        issue(0, 1'b0, 32'h10, 32'h0, w, ss);
        check_eq("b2b_accept_wait", w, 0);
        wait_rsp(0, 20, lat);
        check_eq("rd_latency", lat, 1);

        // Unmapped address: one-cycle bus error, no slave strobe, zero data
        next_cycle();
        sb_q.push_back('{0, 1'b1, 1'b1, 32'h0});
        issue(0, 1'b0, 32'h0500_0000, 32'h0, w, ss);
        check_eq("unmapped_no_stb", ss, 2'b00);
        wait_rsp(0, 20, lat);
        check_eq("decerr_latency", lat, 1);
        @(negedge clk);
        check_eq("decerr_one_cycle", m_err_o, 2'b00);

        // Handover to master 1, read from slave 1
        next_cycle();
        m_cyc = 2'b10;
        sb_q.push_back('{1, 1'b0, 1'b1, 32'hA5A5_0024});
        issue(1, 1'b0, 32'h0100_0024, 32'h0, w, ss);
        check_eq("slave1_stb", ss, 2'b10);
        wait_rsp(1, 20, lat);
        check_eq("grant_m1", grant_o, 2'b10);
        next_cycle();
        m_cyc = 2'b00;

        // Round-robin with 3-cycle tenures and immediate re-requests
        do_reset();
        for (int i = 0; i < 13; i++) begin
            next_cycle();
            m_cyc = arb_cyc[i];
            @(negedge clk);
            check_eq($sformatf("rr_grant_%0d", i), grant_o, arb_gnt[i]);
            for (int m = 0; m < 2; m++)
                if (arb_cyc[i][m] && !arb_gnt[i][m])
                    check_eq($sformatf("rr_stall_%0d_m%0d", i, m), m_stall_o[m], 1'b1);
        end
        next_cycle();
        m_cyc = 2'b00;

        // Owner releases while the slave holds ack back; late ack must vanish
        next_cycle();
        s0_delay = 5;
        m_cyc[0] = 1'b1;
        issue(0, 1'b0, 32'h10, 32'h0, w, ss);
        @(negedge clk);
        next_cycle();
        m_cyc[0] = 1'b0;
        @(negedge clk);
        check_eq("release_scyc", s_cyc_o, 2'b00);
        @(negedge clk);
        check_eq("release_idle", grant_o, 2'b00);
        cnt  = 0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (m_ack_o[0]) cnt++;
            if (s0_ack) seen++;
        end
        check_eq("late_ack_dropped", cnt, 0);
        check_eq("late_ack_seen", seen, 1);
        s0_delay = 1;

        // Slave never acks
        next_cycle();
        s0_noack = 1'b1;
        m_cyc[0] = 1'b1;
`ifdef WB_SHARED_TIMEOUT_EN
        sb_q.push_back('{0, 1'b1, 1'b0, 32'h0});
        issue(0, 1'b0, 32'h20, 32'h0, w, ss);
        wait_rsp(0, 50, lat);
        check_eq("timeout_latency", lat, 8);
        check_eq("timeout_abort_scyc", s_cyc_o[0], 1'b0);
        @(negedge clk);
        check_eq("timeout_abort_one_cycle", s_cyc_o[0], 1'b1);
`else
        issue(0, 1'b0, 32'h20, 32'h0, w, ss);
        cnt = 0;
        repeat (110) begin
            @(negedge clk);
            if (m_stall_o[0] && !m_err_o[0] && !m_ack_o[0]) cnt++;
        end
        check_eq("no_timeout_stall", cnt, 110);
`endif
        next_cycle();
        s0_noack = 1'b0;
        m_cyc    = 2'b00;

        // Reset in the middle of a read, then master 0 must win first
        next_cycle();
        s0_delay = 4;
        m_cyc[0] = 1'b1;
        issue(0, 1'b0, 32'h10, 32'h0, w, ss);
        rst = 1'b1;
        next_cycle();
        rst   = 1'b0;
        m_cyc = 2'b11;
        @(negedge clk);
        check_eq("midread_reset_outputs",
                 {m_ack_o, m_err_o, grant_o, s_cyc_o, s_stb_o, s_we_o,
                  m_dat_o, s_adr_o, s_dat_o, s_sel_o}, '0);
        check_eq("midread_reset_stall", m_stall_o, 2'b11);
        next_cycle();
        @(negedge clk);
        check_eq("post_reset_grant", grant_o, 2'b01);
        s0_delay = 1;
        next_cycle();
        m_cyc = 2'b00;
        repeat (6) next_cycle();

        check_eq("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
